i2c_pot_target: RTL

Synthesizable I2C target that emulates the DS3502 digital potentiometer on the board's I2C bus. It gives the existing 200 kHz DS3502 write master a loopback target for system-level simulation and on-chip self-test, and lets an FPGA-resident wiper model replace the physical part. It handles address match, register-pointer and data writes, and register reads with repeated START. It exposes the current wiper code and an update strobe to fabric logic.

---
 rtl/i2c_pot_target.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_pot_target.sv
// ============================================================================
// Module   : i2c_pot_target
// Brief    : I2C target emulating a DS3502 digital potentiometer (WR/CR regs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_pot_target #(
  parameter logic [6:0] DEV_ADDR   = 7'b0101000,
  parameter int         FILTER_LEN = 3,
  parameter logic [6:0] WR_RESET   = 7'h40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [6:0] wiper,
  output logic [7:0] ctrl,
  output logic       wiper_upd,
  output logic       busy
);

  localparam logic [3:0] c_FLIM = 4'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_REG, S_ACK_R,
    S_WDATA, S_ACK_W, S_RDATA, S_MACK, S_IGNORE
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  assign w_raw = {scl_i, sda_i};

  // Per line: 2-FF synchronizer, then the level must persist FILTER_LEN clk
  generate
    for (genvar g = 0; g < 2; g++) begin : g_filt
      logic [1:0] r_sync;
      logic [3:0] r_cnt;
      logic       r_lvl;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_sync <= 2'b11;
          r_cnt  <= 4'd0;
          r_lvl  <= 1'b1;
        end else begin
          r_sync <= {r_sync[0], w_raw[g]};
          if (r_sync[1] == r_lvl) begin
            r_cnt <= 4'd0;
          end else if (r_cnt == c_FLIM) begin
            r_lvl <= r_sync[1];
            r_cnt <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      end
      assign w_filt[g] = r_lvl;
    end
  endgenerate

  logic w_scl, w_sda;
  logic r_scl_d, r_sda_d;
  assign w_scl = w_filt[1];
  assign w_sda = w_filt[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_start, w_stop, w_rise, w_fall;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic [3:0] r_bits;
  logic       r_rw;
  logic [7:0] w_rd_data;
  logic [7:0] w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  always_comb begin
    w_rd_data = 8'h00;
    case (r_ptr)
      8'h00:   w_rd_data = {1'b0, wiper};
      8'h02:   w_rd_data = ctrl;
      default: w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_ptr     <= 8'h00;
      r_bits    <= 4'd0;
      r_rw      <= 1'b0;
      sda_oe    <= 1'b0;
      wiper     <= WR_RESET;
      ctrl      <= 8'h00;
      wiper_upd <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wiper_upd <= 1'b0;
      // Bus conditions override bit decoding in every state
      if (w_stop) begin
        r_state <= S_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        r_bits  <= 4'd0;
      end else if (w_start) begin
        r_state <= S_ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        r_bits  <= 4'd0;
      end else begin
        case (r_state)
          S_ADDR, S_REG, S_WDATA: begin
            if (w_rise) begin
              r_shift <= w_byte;
              r_bits  <= r_bits + 4'd1;
              if (r_state == S_WDATA && r_bits == 4'd7) begin
                if (r_ptr == 8'h00) begin
                  wiper     <= w_byte[6:0];
                  wiper_upd <= 1'b1;
                end else if (r_ptr == 8'h02) begin
                  ctrl <= w_byte;
                end
              end
            end else if (w_fall && r_bits == 4'd8) begin
              if (r_state == S_ADDR) begin
                if (r_shift[7:1] == DEV_ADDR) begin
                  sda_oe  <= 1'b1;
                  busy    <= 1'b1;
                  r_rw    <= r_shift[0];
                  r_state <= S_ACK_A;
                end else begin
                  r_state <= S_IGNORE;
                end
              end else if (r_state == S_REG) begin
                r_ptr   <= r_shift;
                sda_oe  <= 1'b1;
                r_state <= S_ACK_R;
              end else begin
                sda_oe  <= 1'b1;
                r_state <= S_ACK_W;
              end
            end
          end
          S_ACK_A: begin
            if (w_fall) begin
              if (r_rw) begin
                r_shift <= w_rd_data;
                sda_oe  <= ~w_rd_data[7];
                r_bits  <= 4'd1;
                r_state <= S_RDATA;
              end else begin
                sda_oe  <= 1'b0;
                r_bits  <= 4'd0;
                r_state <= S_REG;
              end
            end
          end
          S_ACK_R, S_ACK_W: begin
            if (w_fall) begin
              sda_oe  <= 1'b0;
              r_bits  <= 4'd0;
              r_state <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (w_fall) begin
              if (r_bits == 4'd8) begin
                sda_oe  <= 1'b0;
                r_state <= S_MACK;
              end else begin
                sda_oe  <= ~r_shift[6];
                r_shift <= {r_shift[6:0], 1'b0};
                r_bits  <= r_bits + 4'd1;
              end
            end
          end
          // A master ACK re-enters the read-ACK slot, which reloads at the next FALL
          S_MACK: begin
            if (w_rise) begin
              if (!w_sda) begin
                r_state <= S_ACK_A;
              end else begin
                busy    <= 1'b0;
                r_state <= S_IGNORE;
              end
            end
          end
          S_IDLE, S_IGNORE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
